// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: registered 1-to-N valid/ready demultiplexer with out-of-range drop flag and saturating counter
module stream_demux_1xn #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_drop,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int NP = 2 ** SEL_W;
    logic             hold_v_q, hold_v_d;
    logic [SEL_W-1:0] hold_sel_q, hold_sel_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NP-1:0]    rdy_ext;
    logic             sel_rdy, drain, acc, sel_ok;
    // pad ready to the full select range so indexing by hold_sel_q is always in bounds
    assign rdy_ext  = NP'(out_ready);
    assign sel_rdy  = rdy_ext[hold_sel_q];
    assign drain    = hold_v_q && sel_rdy && !flush;
    assign in_ready = !flush && (!hold_v_q || sel_rdy);
    assign acc      = in_valid && in_ready;
    assign sel_ok   = {1'b0, in_sel} < (SEL_W + 1)'(N);
    assign out_data = hold_data_q;
    assign err_drop = err_q;
    assign drop_cnt = cnt_q;
    always_comb begin
        hold_v_d    = flush ? 1'b0 : (acc && sel_ok) ? 1'b1 : drain ? 1'b0 : hold_v_q;
        hold_sel_d  = (acc && sel_ok) ? in_sel : hold_sel_q;
        hold_data_d = (acc && sel_ok) ? in_data : hold_data_q;
        err_d       = acc && !sel_ok;
        cnt_d       = (err_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    always_comb begin
        out_valid = '0;
        for (int i = 0; i < N; i++)
            out_valid[i] = hold_v_q && !flush && (hold_sel_q == SEL_W'(i));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_v_q    <= 1'b0;
            hold_sel_q  <= '0;
            hold_data_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_sel_q  <= hold_sel_d;
            hold_data_q <= hold_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb_stream_demux_1xn: scoreboard bench; N=4 instance for routing/stall/flush, N=3 instance for drops
module tb_stream_demux_1xn;
    typedef struct packed {
        logic [1:0]  sel;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = '0;
    logic [63:0] in_data = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [63:0] out_data;
    logic        err_drop;
    logic [7:0]  drop_cnt;

    logic        b_flush = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [1:0]  b_in_sel = '0;
    logic [63:0] b_in_data = '0;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready = 3'b111;
    logic [63:0] b_out_data;
    logic        b_err_drop;
    logic [7:0]  b_drop_cnt;

    int cmp = 0;
    int errs = 0;
    beat_t q[$];
    int    dq[$];

    stream_demux_1xn #(.WIDTH(64), .N(4), .SEL_W(2), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .err_drop(err_drop), .drop_cnt(drop_cnt)
    );

    stream_demux_1xn #(.WIDTH(64), .N(3), .SEL_W(2), .CNT_W(8)) dut3 (
        .clk(clk), .reset_n(reset_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sel(b_in_sel), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .err_drop(b_err_drop), .drop_cnt(b_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [63:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("onehot", 64'($onehot0(out_valid)), 64'd1);
            if (flush) chk("flush_valid", 64'(out_valid), 64'd0);
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (q.size() == 0) begin
                        cmp++;
                        errs++;
                        $display("FAIL xfer_unexpected: got ch %0d data %0h expected none", i, out_data);
                    end else begin
                        beat_t e;
                        e = q.pop_front();
                        chk("xfer_sel", 64'(i), 64'(e.sel));
                        chk("xfer_data", out_data, e.data);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && b_err_drop) begin
            chk("drop_valid", 64'(b_out_valid), 64'd0);
            if (dq.size() == 0) begin
                cmp++;
                errs++;
                $display("FAIL drop_unexpected: got cnt %0d expected no drop", b_drop_cnt);
            end else begin
                int e;
                e = dq.pop_front();
                chk("drop_cnt", 64'(b_drop_cnt), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        step();
        // 1: reset while a beat is held
        out_ready = 4'b0000;
        drive(1'b1, 2'd2, 64'h22);
        step();
        drive(1'b0, 2'd0, 64'h0);
        chk("t1_held", 64'(out_valid), 64'b0100);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_rst_valid", 64'(out_valid), 64'd0);
        chk("t1_rst_data", out_data, 64'd0);
        chk("t1_rst_cnt", 64'(drop_cnt), 64'd0);
        step();
        reset_n = 1'b1;
        #1 chk("t1_ready", 64'(in_ready), 64'd1);
        // 2: back-to-back
        out_ready = 4'b1111;
        drive(1'b1, 2'd0, 64'hA0); q.push_back('{2'd0, 64'hA0});
        #1 chk("t2_rdy0", 64'(in_ready), 64'd1);
        step();
        chk("t2_v0", 64'(out_valid), 64'b0001);
        drive(1'b1, 2'd1, 64'hA1); q.push_back('{2'd1, 64'hA1});
        #1 chk("t2_rdy1", 64'(in_ready), 64'd1);
        step();
        chk("t2_v1", 64'(out_valid), 64'b0010);
        drive(1'b1, 2'd3, 64'hA3); q.push_back('{2'd3, 64'hA3});
        #1 chk("t2_rdy2", 64'(in_ready), 64'd1);
        step();
        chk("t2_v3", 64'(out_valid), 64'b1000);
        chk("t2_d3", out_data, 64'hA3);
        drive(1'b0, 2'd0, 64'h0);
        step();
        chk("t2_idle", 64'(out_valid), 64'd0);
        // 3: stall, then drain with same-cycle accept
        out_ready = 4'b1011;
        drive(1'b1, 2'd2, 64'h55); q.push_back('{2'd2, 64'h55});
        step();
        drive(1'b1, 2'd0, 64'h66);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_v", 64'(out_valid), 64'b0100);
            chk("t3_d", out_data, 64'h55);
            chk("t3_rdy", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 4'b1111;
        #1 chk("t3_rdy_drain", 64'(in_ready), 64'd1);
        q.push_back('{2'd0, 64'h66});
        step();
        chk("t3_v_new", 64'(out_valid), 64'b0001);
        chk("t3_d_new", out_data, 64'h66);
        drive(1'b0, 2'd0, 64'h0);
        step();
        // 5: flush a stalled beat
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 64'h77);
        step();
        chk("t5_held", 64'(out_valid), 64'b0010);
        flush = 1'b1;
        drive(1'b1, 2'd0, 64'h88);
        #1;
        chk("t5_rdy", 64'(in_ready), 64'd0);
        chk("t5_v", 64'(out_valid), 64'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 2'd0, 64'h0);
        out_ready = 4'b1111;
        #1 chk("t5_after", 64'(out_valid), 64'd0);
        drive(1'b1, 2'd3, 64'h99); q.push_back('{2'd3, 64'h99});
        #1 chk("t5_rdy_next", 64'(in_ready), 64'd1);
        step();
        chk("t5_v_next", 64'(out_valid), 64'b1000);
        drive(1'b0, 2'd0, 64'h0);
        step();
        // 6: ready on the wrong channels
        out_ready = 4'b0000;
        drive(1'b1, 2'd0, 64'hC0); q.push_back('{2'd0, 64'hC0});
        step();
        drive(1'b0, 2'd0, 64'h0);
        out_ready = 4'b1110;
        #1 chk("t6_v_a", 64'(out_valid), 64'b0001);
        step();
        chk("t6_v_b", 64'(out_valid), 64'b0001);
        out_ready = 4'b0001;
        step();
        chk("t6_gone", 64'(out_valid), 64'd0);
        step();
        chk("t6_nodup", 64'(out_valid), 64'd0);
        // 4: out-of-range drops on the N=3 instance
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 64'hFF;
        dq.push_back(1);
        step();
        b_in_valid = 1'b0;
        chk("t4_err", 64'(b_err_drop), 64'd1);
        chk("t4_cnt", 64'(b_drop_cnt), 64'd1);
        chk("t4_nov", 64'(b_out_valid), 64'd0);
        step();
        chk("t4_pulse", 64'(b_err_drop), 64'd0);
        chk("t4_cnt_hold", 64'(b_drop_cnt), 64'd1);
        b_in_valid = 1'b1;
        for (int k = 2; k <= 300; k++) begin
            dq.push_back(k > 255 ? 255 : k);
            step();
        end
        b_in_valid = 1'b0;
        step();
        chk("t4_sat", 64'(b_drop_cnt), 64'd255);
        chk("t4_err_off", 64'(b_err_drop), 64'd0);
        b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = 64'h11;
        step();
        b_in_valid = 1'b0;
        chk("t4_valid_v", 64'(b_out_valid), 64'b010);
        chk("t4_valid_d", b_out_data, 64'h11);
        repeat (2) step();
        chk("sb_empty", 64'(q.size()), 64'd0);
        chk("dq_empty", 64'(dq.size()), 64'd0);
        chk("n4_no_drops", 64'(drop_cnt), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
